// File: rtl/memory_sequencer_if.sv
// Request/response and memory-array bus for memory_sequencer.
// slave: sequencer side; master: requester plus memory array side.
interface memory_sequencer_if;
    // request channel
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    // read response channel
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    // 4x8 byte memory array
    logic [7:0] mem_data;
    logic       mem_store;
    logic [1:0] mem_addr;
    logic [7:0] mem_q;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_data,
        output mem_data, mem_store, mem_addr
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_data, mem_store, mem_addr
    );
endinterface

// File: rtl/memory_sequencer.sv
// Sequences single-byte reads/writes to a 4x8 byte memory array.
// Ports: clk, reset (sync, active-high), bus (memory_sequencer_if.slave).
module memory_sequencer #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    memory_sequencer_if.slave   bus
);

    localparam logic [3:0] STROBE_LIM = 4'(STROBE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        SETTLE,
        CAPTURE,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       mem_store;
    logic [1:0] mem_addr;
    logic [7:0] mem_data;

    // All outputs are registers so mem_store never glitches and
    // only rises after mem_addr/mem_data have settled for a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            mem_store <= 1'b0;
            mem_addr  <= 2'd0;
            mem_data  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    // req_ready is high in IDLE, so valid alone accepts
                    if (bus.req_valid) begin
                        mem_addr  <= bus.req_addr;
                        mem_data  <= bus.req_wdata;
                        req_ready <= 1'b0;
                        state     <= bus.req_write ? SETUP : SETTLE;
                    end
                end
                SETUP: begin
                    mem_store <= 1'b1;
                    cnt       <= 4'd1;
                    state     <= STROBE;
                end
                STROBE: begin
                    if (cnt == STROBE_LIM) begin
                        mem_store <= 1'b0;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HOLD: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                SETTLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // address has been stable since SETTLE
                    rsp_data  <= bus.mem_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_store <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.mem_store = mem_store;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_data  = mem_data;

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: two instances (STROBE_CYCLES 1 and 4)
// share stimulus; a timeline model predicts every output each cycle.
module tb_memory_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [1:0] req_addr  = 2'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_ready = 1'b1;

    memory_sequencer_if bus_a();
    memory_sequencer_if bus_b();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_write = req_write;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_a.rsp_ready = rsp_ready;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_write = req_write;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;
    assign bus_b.rsp_ready = rsp_ready;

    // memory arrays driven by the DUT strobes
    logic [7:0] mem_a [4] = '{default: 8'd0};
    logic [7:0] mem_b [4] = '{default: 8'd0};
    always @(posedge clk) begin
        if (bus_a.mem_store) mem_a[bus_a.mem_addr] <= bus_a.mem_data;
        if (bus_b.mem_store) mem_b[bus_b.mem_addr] <= bus_b.mem_data;
    end
    assign bus_a.mem_q = mem_a[bus_a.mem_addr];
    assign bus_b.mem_q = mem_b[bus_b.mem_addr];

    memory_sequencer #(.STROBE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    memory_sequencer #(.STROBE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    logic       o_ready [2];
    logic       o_rv    [2];
    logic       o_store [2];
    logic [7:0] o_rd    [2];
    logic [7:0] o_md    [2];
    logic [1:0] o_ma    [2];
    assign o_ready[0] = bus_a.req_ready;
    assign o_ready[1] = bus_b.req_ready;
    assign o_rv[0]    = bus_a.rsp_valid;
    assign o_rv[1]    = bus_b.rsp_valid;
    assign o_store[0] = bus_a.mem_store;
    assign o_store[1] = bus_b.mem_store;
    assign o_rd[0]    = bus_a.rsp_data;
    assign o_rd[1]    = bus_b.rsp_data;
    assign o_md[0]    = bus_a.mem_data;
    assign o_md[1]    = bus_b.mem_data;
    assign o_ma[0]    = bus_a.mem_addr;
    assign o_ma[1]    = bus_b.mem_addr;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: k = cycles since accept. Write: store on k=2..S+1,
    // idle again at k=S+3. Read: response at k=3 until consumed.
    int         S     [2] = '{1, 4};
    bit         busy  [2] = '{default: 1'b0};
    bit         mwr   [2] = '{default: 1'b0};
    int         k     [2] = '{default: 0};
    logic [1:0] maddr [2] = '{default: 2'd0};
    logic [7:0] mdata [2] = '{default: 8'd0};
    bit         mrv   [2] = '{default: 1'b0};
    logic [7:0] mrd   [2] = '{default: 8'd0};
    logic [7:0] mm    [2][4] = '{default: '{default: 8'd0}};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                busy[i] = 1'b0; k[i] = 0; mrv[i] = 1'b0;
                maddr[i] = 2'd0; mdata[i] = 8'd0; mrd[i] = 8'd0;
            end else if (!busy[i]) begin
                if (req_valid) begin
                    busy[i] = 1'b1; k[i] = 1; mwr[i] = req_write;
                    maddr[i] = req_addr; mdata[i] = req_wdata;
                    if (req_write) mm[i][req_addr] = req_wdata;
                end
            end else if (mwr[i]) begin
                k[i]++;
                if (k[i] == S[i] + 3) busy[i] = 1'b0;
            end else if (k[i] < 3) begin
                k[i]++;
                if (k[i] == 3) begin
                    mrv[i] = 1'b1;
                    mrd[i] = mm[i][maddr[i]];
                end
            end else if (rsp_ready) begin
                busy[i] = 1'b0;
                mrv[i]  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                bit es;
                es = busy[i] && mwr[i] && k[i] >= 2 && k[i] <= S[i] + 1;
                chk($sformatf("d%0d_req_ready", i), o_ready[i], !busy[i]);
                chk($sformatf("d%0d_rsp_valid", i), o_rv[i], mrv[i]);
                chk($sformatf("d%0d_rsp_data", i), o_rd[i], mrd[i]);
                chk($sformatf("d%0d_mem_store", i), o_store[i], es);
                chk($sformatf("d%0d_mem_addr", i), o_ma[i], maddr[i]);
                chk($sformatf("d%0d_mem_data", i), o_md[i], mdata[i]);
            end
        end
    end

    // returns at the negedge where k=1 is visible
    task automatic do_req(input bit w, input logic [1:0] a,
                          input logic [7:0] d);
        int n = 0;
        while (!(o_ready[0] && o_ready[1]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 0, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    logic [7:0] wr_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int ca, cb;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_ready", o_ready[0], 1);
        chk("rst_rv", o_rv[0], 0);
        chk("rst_store", o_store[0], 0);
        chk("rst_addr", o_ma[0], 0);
        chk("rst_data", o_md[0], 0);
        reset = 1'b0;
        @(negedge clk);

        // single-cycle strobe write
        do_req(1'b1, 2'd2, 8'hA5);
        chk("w_addr_k1", o_ma[0], 2);
        chk("w_data_k1", o_md[0], 8'hA5);
        chk("w_store_k1", o_store[0], 0);
        @(negedge clk);
        chk("w_store_k2", o_store[0], 1);
        @(negedge clk);
        chk("w_store_k3", o_store[0], 0);
        chk("w_ready_k3", o_ready[0], 0);
        @(negedge clk);
        chk("w_ready_k4", o_ready[0], 1);

        // read with stalled consumer
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 8'h00);
        repeat (2) @(negedge clk);
        chk("r_rv_k3", o_rv[0], 1);
        chk("r_rd_k3", o_rd[0], 8'hA5);
        repeat (4) @(negedge clk);
        chk("r_rv_k7", o_rv[1], 1);
        chk("r_rd_k7", o_rd[1], 8'hA5);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("r_rv_done", o_rv[0], 0);

        // fill and read back in reverse
        for (int i = 0; i < 4; i++) do_req(1'b1, 2'(i), wr_tab[i]);
        for (int i = 3; i >= 0; i--) begin
            do_req(1'b0, 2'(i), 8'h00);
            repeat (2) @(negedge clk);
            chk($sformatf("rb_a%0d", i), o_rd[0], wr_tab[i]);
            chk($sformatf("rb_b%0d", i), o_rd[1], wr_tab[i]);
        end

        // strobe width per instance
        do_req(1'b1, 2'd1, 8'h5A);
        ca = 0; cb = 0;
        for (int j = 1; j <= 8; j++) begin
            if (o_store[0]) ca++;
            if (o_store[1]) cb++;
            if (j <= 7) chk("b_addr_stable", o_ma[1], 1);
            @(negedge clk);
        end
        chk("a_store_cycles", ca, 1);
        chk("b_store_cycles", cb, 4);

        // requests while busy are ignored
        do_req(1'b1, 2'd3, 8'h77);
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = 2'd0; req_wdata = 8'hFF;
        @(negedge clk);
        req_write = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_addr", o_ma[0], 3);
        chk("busy_data", o_md[0], 8'h77);
        repeat (6) @(negedge clk);

        // reset during strobe
        do_req(1'b1, 2'd2, 8'hC3);
        @(negedge clk);
        chk("rs_store_on_a", o_store[0], 1);
        chk("rs_store_on_b", o_store[1], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_store_a", o_store[0], 0);
        chk("rs_store_b", o_store[1], 0);
        chk("rs_ready_b", o_ready[1], 1);
        chk("rs_addr_b", o_ma[1], 0);
        chk("rs_data_b", o_md[1], 0);

        // reset during response
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd1, 8'h00);
        repeat (2) @(negedge clk);
        chk("rr_rv_on", o_rv[0], 1);
        chk("rr_rd_on", o_rd[0], 8'h5A);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        chk("rr_rv_off", o_rv[0], 0);
        chk("rr_rd_off", o_rd[0], 0);

        // reset wins over a simultaneous request
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 2'd3; req_wdata = 8'hEE;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rv_ready", o_ready[0], 1);
        chk("rv_store", o_store[1], 0);

        // normal read after all resets
        do_req(1'b0, 2'd0, 8'h00);
        repeat (2) @(negedge clk);
        chk("final_rd", o_rd[1], 8'h11);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
